// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, buy/refund/restock transactions,
// yes/no outcome hold, and a multiplexed active-low hex credit display.
module vending_machine_multi #(
  parameter int N_ITEMS     = 4,
  parameter int SEL_W       = 2,
  parameter int COIN_W      = 4,
  parameter int CREDIT_W    = 8,
  parameter int STOCK_W     = 4,
  parameter int INIT_STOCK  = 5,
  parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd12, 8'd10, 8'd8, 8'd5},
  parameter int HOLD_CYC    = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [COIN_W-1:0]   b_in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                refund,
  input  logic                restock,
  output logic                yes,
  output logic                no,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic [N_ITEMS-1:0]  empty,
  output logic [6:0]          seg,
  output logic [3:0]          an
);

  localparam int HC_W = $clog2(HOLD_CYC) + 1;
  localparam int RD_W = $clog2(REFRESH_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_FAIL,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  // Request bit order: {restock, refund, buy, load}
  logic [3:0]          req_s_q, req_s_d;
  logic [3:0]          req_p_q, req_p_d;
  logic [COIN_W-1:0]   coin_s_q, coin_s_d;
  logic [SEL_W-1:0]    sel_s_q, sel_s_d;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                yes_q, yes_d;
  logic                no_q, no_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                change_valid_q, change_valid_d;
  logic [HC_W-1:0]     hold_q, hold_d;

  logic [RD_W-1:0]     refresh_q, refresh_d;
  logic [1:0]          digit_q, digit_d;
  logic [6:0]          seg_q, seg_d;
  logic [3:0]          an_q, an_d;

  logic [3:0]          rise;
  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_loaded;
  logic                sel_found;
  logic [CREDIT_W-1:0] price_sel;
  logic [STOCK_W-1:0]  stock_sel;
  logic [15:0]         credit_ext;
  logic [3:0]          nibble;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      req_s_q        <= '0;
      req_p_q        <= '0;
      coin_s_q       <= '0;
      sel_s_q        <= '0;
      credit_q       <= '0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      sel_q          <= '0;
      yes_q          <= 1'b0;
      no_q           <= 1'b0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      hold_q         <= '0;
      refresh_q      <= '0;
      digit_q        <= '0;
      seg_q          <= 7'b1000000;
      an_q           <= 4'b1110;
    end else begin
      state_q        <= state_d;
      req_s_q        <= req_s_d;
      req_p_q        <= req_p_d;
      coin_s_q       <= coin_s_d;
      sel_s_q        <= sel_s_d;
      credit_q       <= credit_d;
      stock_q        <= stock_d;
      sel_q          <= sel_d;
      yes_q          <= yes_d;
      no_q           <= no_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      hold_q         <= hold_d;
      refresh_q      <= refresh_d;
      digit_q        <= digit_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
    end
  end

  // Inputs are sampled once, then compared with their previous sample to find rises.
  always_comb begin
    req_s_d  = {restock, refund, buy, load};
    req_p_d  = req_s_q;
    coin_s_d = b_in;
    sel_s_d  = sel;
    rise     = req_s_q & ~req_p_q;

    credit_sum    = {1'b0, credit_q} + (CREDIT_W+1)'(coin_s_q);
    credit_loaded = credit_q;
    if (rise[0]) begin
      credit_loaded = credit_sum[CREDIT_W] ? {CREDIT_W{1'b1}} : credit_sum[CREDIT_W-1:0];
    end

    sel_found = 1'b0;
    price_sel = '0;
    stock_sel = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_found = 1'b1;
        price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
        stock_sel = stock_q[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    sel_d          = sel_q;
    yes_d          = yes_q;
    no_d           = no_q;
    change_d       = change_q;
    change_valid_d = 1'b0;
    hold_d         = hold_q;

    case (state_q)
      // The coin lands even when another request wins this cycle.
      S_IDLE: begin
        credit_d = credit_loaded;
        if (rise[2]) begin
          change_d       = credit_loaded;
          change_valid_d = 1'b1;
          credit_d       = '0;
        end else if (rise[1]) begin
          sel_d   = sel_s_q;
          state_d = S_CHECK;
        end else if (rise[3]) begin
          for (int i = 0; i < N_ITEMS; i++) begin
            if (sel_s_q == SEL_W'(i)) stock_d[i] = STOCK_W'(INIT_STOCK);
          end
        end
      end
      S_CHECK: begin
        if (!sel_found || stock_sel == '0 || credit_q < price_sel) state_d = S_FAIL;
        else state_d = S_VEND;
      end
      S_VEND: begin
        credit_d = credit_q - price_sel;
        for (int i = 0; i < N_ITEMS; i++) begin
          if (sel_q == SEL_W'(i)) stock_d[i] = stock_q[i] - STOCK_W'(1);
        end
        yes_d   = 1'b1;
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_FAIL: begin
        no_d    = 1'b1;
        hold_d  = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (hold_q == HC_W'(HOLD_CYC - 1)) begin
          yes_d   = 1'b0;
          no_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // seg is computed for the digit that an will select after this edge, so both switch together.
  always_comb begin
    if (refresh_q == RD_W'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      digit_d   = digit_q + 2'd1;
    end else begin
      refresh_d = refresh_q + RD_W'(1);
      digit_d   = digit_q;
    end
    credit_ext = 16'(credit_q);
    nibble     = credit_ext[{digit_d, 2'b00} +: 4];
    seg_d      = hex_glyph(nibble);
    an_d       = ~(4'b0001 << digit_d);
  end

  always_comb begin
    for (int i = 0; i < N_ITEMS; i++) empty[i] = (stock_q[i] == '0);
  end

  assign yes          = yes_q;
  assign no           = no_q;
  assign change       = change_q;
  assign change_valid = change_valid_q;
  assign seg          = seg_q;
  assign an           = an_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Randomised and directed bench for vending_machine_multi, checked against a
// transaction-level model of credit, stock and outcome pulse timing.
module tb_vending_machine_multi;

  localparam int N_ITEMS = 4;
  localparam int INIT_STOCK = 5;
  localparam int MAX_CREDIT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] b_in = '0;
  logic [1:0] sel = '0;
  logic       buy = 1'b0;
  logic       refund = 1'b0;
  logic       restock = 1'b0;
  logic       yes, no, change_valid;
  logic [7:0] change;
  logic [3:0] empty;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  int price [N_ITEMS] = '{5, 8, 10, 12};
  int m_credit;
  int m_stock [N_ITEMS];

  // Outcome pulses seen k falling edges after the request was driven.
  localparam logic [12:0] PULSE_OUTCOME = 13'b0_0000_1111_0000;
  localparam logic [12:0] PULSE_CHANGE  = 13'b0_0000_0000_0100;

  vending_machine_multi #(
    .N_ITEMS(4), .SEL_W(2), .COIN_W(4), .CREDIT_W(8), .STOCK_W(4),
    .INIT_STOCK(INIT_STOCK), .PRICES({8'd12, 8'd10, 8'd8, 8'd5}),
    .HOLD_CYC(4), .REFRESH_DIV(2)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .b_in(b_in), .sel(sel), .buy(buy),
    .refund(refund), .restock(restock), .yes(yes), .no(no), .change(change),
    .change_valid(change_valid), .empty(empty), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  function automatic int seg2hex(input logic [6:0] s);
    logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    seg2hex = -1;
    for (int i = 0; i < 16; i++) if (glyphs[i] == s) seg2hex = i;
  endfunction

  function automatic logic [3:0] model_empty();
    logic [3:0] e;
    for (int i = 0; i < N_ITEMS; i++) e[i] = (m_stock[i] == 0);
    return e;
  endfunction

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < N_ITEMS; i++) m_stock[i] = INIT_STOCK;
  endtask

  // Transaction-level reference: coin first, then refund > buy > restock.
  task automatic model_txn(input bit ld, input int b, input bit by, input int s,
                           input bit rf, input bit rs, output logic [12:0] ey,
                           output logic [12:0] en, output logic [12:0] ecv, output int echg);
    ey = '0; en = '0; ecv = '0; echg = -1;
    if (ld) m_credit = (m_credit + b > MAX_CREDIT) ? MAX_CREDIT : m_credit + b;
    if (rf) begin
      echg = m_credit;
      ecv = PULSE_CHANGE;
      m_credit = 0;
    end else if (by) begin
      if (s < N_ITEMS && m_stock[s] > 0 && m_credit >= price[s]) begin
        m_credit -= price[s];
        m_stock[s] -= 1;
        ey = PULSE_OUTCOME;
      end else begin
        en = PULSE_OUTCOME;
      end
    end else if (rs) begin
      if (s < N_ITEMS) m_stock[s] = INIT_STOCK;
    end
  endtask

  // Drives one request cycle and records the outputs over the following 12 clocks.
  task automatic run_txn(input bit ld, input int b, input bit by, input int s,
                         input bit rf, input bit rs, input bit noise,
                         output logic [12:0] y, output logic [12:0] n,
                         output logic [12:0] cv, output int chg);
    y = '0; n = '0; cv = '0; chg = -1;
    @(negedge clk);
    load = ld; b_in = 4'(b); buy = by; sel = 2'(s); refund = rf; restock = rs;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      y[k] = yes; n[k] = no; cv[k] = change_valid;
      if (change_valid) chg = int'(change);
      if (k == 1) begin
        load = 0; buy = 0; refund = 0; restock = 0; sel = ~2'(s);
      end
      if (noise && k == 5) begin load = 1; b_in = 4'd9; buy = 1; end
      if (noise && k == 6) begin load = 0; buy = 0; end
    end
  endtask

  // Reconstructs the 16-bit displayed value by scanning all four digits.
  task automatic read_display(output int val);
    int d [4];
    bit seen [4];
    bit all_seen;
    val = -1;
    all_seen = 0;
    for (int j = 0; j < 4; j++) begin d[j] = -1; seen[j] = 0; end
    for (int c = 0; c < 40 && !all_seen; c++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (an == ~(4'b0001 << j)) begin d[j] = seg2hex(seg); seen[j] = 1; end
      end
      all_seen = seen[0] && seen[1] && seen[2] && seen[3];
    end
    if (all_seen && d[0] >= 0 && d[1] >= 0 && d[2] >= 0 && d[3] >= 0)
      val = (d[3] << 12) | (d[2] << 8) | (d[1] << 4) | d[0];
  endtask

  // Runs a transaction through both DUT and model and compares every observable.
  task automatic txn_and_check(input string tag, input bit ld, input int b, input bit by,
                               input int s, input bit rf, input bit rs, input bit noise);
    logic [12:0] y, n, cv, ey, en, ecv;
    int chg, echg, disp;
    run_txn(ld, b, by, s, rf, rs, noise, y, n, cv, chg);
    model_txn(ld, b, by, s, rf, rs, ey, en, ecv, echg);
    checks++;
    if (y !== ey) begin errors++; $display("[TB] FAIL %s yes_pulse: got %b want %b", tag, y, ey); end
    checks++;
    if (n !== en) begin errors++; $display("[TB] FAIL %s no_pulse: got %b want %b", tag, n, en); end
    checks++;
    if (cv !== ecv) begin errors++; $display("[TB] FAIL %s change_valid: got %b want %b", tag, cv, ecv); end
    if (ecv != 0) begin
      checks++;
      if (chg != echg) begin errors++; $display("[TB] FAIL %s change: got %0d want %0d", tag, chg, echg); end
    end
    checks++;
    if (empty !== model_empty()) begin
      errors++; $display("[TB] FAIL %s empty: got %b want %b", tag, empty, model_empty());
    end
    read_display(disp);
    checks++;
    if (disp != m_credit) begin
      errors++; $display("[TB] FAIL %s credit_display: got %0d want %0d", tag, disp, m_credit);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #2;
    checks++;
    if ({yes, no, change_valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b want 000", {yes, no, change_valid});
    end
    checks++;
    if (change !== 8'd0) begin errors++; $display("[TB] FAIL reset_change: got %0d want 0", change); end
    checks++;
    if (empty !== 4'b0000) begin errors++; $display("[TB] FAIL reset_empty: got %b want 0000", empty); end
    checks++;
    if (an !== 4'b1110) begin errors++; $display("[TB] FAIL reset_an: got %b want 1110", an); end
    checks++;
    if (seg !== 7'b1000000) begin errors++; $display("[TB] FAIL reset_seg: got %b want 1000000", seg); end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_vend_basic();
    $display("[TB] basic vend");
    txn_and_check("vend_item0", 1, 6, 1, 0, 0, 0, 0);
  endtask

  task automatic test_vend_refused();
    $display("[TB] refused vend");
    txn_and_check("load3", 1, 3, 0, 0, 0, 0, 0);
    txn_and_check("refuse_item1", 0, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_exact_and_empty();
    int guard = 0;
    $display("[TB] exact credit and empty stock");
    txn_and_check("clear_credit", 0, 0, 0, 0, 1, 0, 0);
    while (m_stock[0] > 0 && guard < 8) begin
      txn_and_check("exact_buy", 1, 5, 1, 0, 0, 0, 0);
      guard++;
    end
    txn_and_check("buy_empty", 1, 5, 1, 0, 0, 0, 0);
    txn_and_check("restock0", 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_saturate();
    $display("[TB] credit saturation");
    for (int i = 0; i < 18; i++) txn_and_check("load15", 1, 15, 0, 0, 0, 0, 0);
    txn_and_check("refund_full", 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic test_priority_and_hold_drop();
    $display("[TB] same-cycle priority and hold drops");
    txn_and_check("refund_wins", 1, 7, 1, 0, 1, 0, 0);
    txn_and_check("hold_noise", 1, 6, 1, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    $display("[TB] random transactions");
    for (int i = 0; i < 40; i++) begin
      int r, b, s;
      bit ld;
      r  = $urandom_range(0, 9);
      b  = $urandom_range(0, 15);
      s  = $urandom_range(0, 3);
      ld = ($urandom_range(0, 3) != 0);
      if (r < 2)      txn_and_check("rand_refund", ld, b, 0, s, 1, 0, 0);
      else if (r < 7) txn_and_check("rand_buy", ld, b, 1, s, 0, 0, r == 6);
      else if (r < 8) txn_and_check("rand_restock", ld, b, 0, s, 0, 1, 0);
      else            txn_and_check("rand_load", 1, b, 0, s, 0, 0, 0);
    end
  endtask

  task automatic test_reset_in_hold();
    int disp;
    $display("[TB] reset during hold");
    txn_and_check("pre_restock2", 0, 0, 0, 2, 0, 1, 0);
    txn_and_check("pre_load", 1, 15, 0, 0, 0, 0, 0);
    @(negedge clk);
    load = 1; b_in = 4'd0; buy = 1; sel = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin load = 0; buy = 0; end
    end
    checks++;
    if (yes !== 1'b1) begin errors++; $display("[TB] FAIL hold_yes_before_rst: got %b want 1", yes); end
    #1 rst = 1;
    #1;
    checks++;
    if ({yes, no, change_valid} !== 3'b000) begin
      errors++; $display("[TB] FAIL async_rst_flags: got %b want 000", {yes, no, change_valid});
    end
    checks++;
    if (an !== 4'b1110) begin errors++; $display("[TB] FAIL async_rst_an: got %b want 1110", an); end
    checks++;
    if (empty !== 4'b0000) begin errors++; $display("[TB] FAIL async_rst_empty: got %b want 0000", empty); end
    @(negedge clk);
    rst = 0;
    model_reset();
    read_display(disp);
    checks++;
    if (disp != 0) begin errors++; $display("[TB] FAIL async_rst_credit: got %0d want 0", disp); end
    txn_and_check("post_rst_buy", 1, 12, 1, 3, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_vend_basic();
    test_vend_refused();
    test_exact_and_empty();
    test_saturate();
    test_priority_and_hold_drop();
    test_random();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
